// File: rtl/pred_sched.sv
// pred_sched: owns the single-port PHT -- clear sweep after reset, IF lookups, and EX counter updates
// buffered in a small FIFO. Defining PRED_SCHED_STATS_EN adds saturating drop_cnt / deny_cnt outputs.
module pred_sched #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [IDX_W-1:0] if_idx,
    output logic             if_gnt,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             ex_valid,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic             ex_taken,
    output logic             init_done,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata
`ifdef PRED_SCHED_STATS_EN
    ,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      deny_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0] FULL_CNT = QDEPTH[PTR_W:0];

    typedef enum logic [1:0] {INIT, IDLE, UPD} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [IDX_W-1:0] r_fifo_idx [QDEPTH];
    logic             r_fifo_tkn [QDEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W:0]   r_count;
    logic [IDX_W-1:0] r_upd_idx;
    logic             r_upd_tkn;
    logic             r_init_done;
    logic             r_pred_valid;

    logic             w_full;
    logic             w_nempty;
    logic             w_pop;
    logic             w_push;
    logic             w_gnt;
    logic [1:0]       w_next_ctr;

    assign w_full   = (r_count == FULL_CNT);
    assign w_nempty = (r_count != '0);
    // A full FIFO takes the port ahead of IF so EX updates are never lost to a steady lookup stream
    assign w_pop    = (r_state == IDLE) && w_nempty && (w_full || !if_req);
    assign w_gnt    = (r_state == IDLE) && if_req && !w_pop;
    assign w_push   = ex_valid && (!w_full || w_pop);

    always_comb begin
        w_next_ctr = tbl_rdata;
        if (r_upd_tkn) begin
            if (tbl_rdata != 2'b11) w_next_ctr = tbl_rdata + 2'd1;
        end else begin
            if (tbl_rdata != 2'b00) w_next_ctr = tbl_rdata - 2'd1;
        end
    end

    // Port drive is combinational so the first clear write lands in the first cycle out of reset
    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        if (!rst) begin
            case (r_state)
                INIT: begin
                    tbl_en   = 1'b1;
                    tbl_we   = 1'b1;
                    tbl_addr = r_sweep;
                end
                IDLE: begin
                    if (w_pop) begin
                        tbl_en   = 1'b1;
                        tbl_addr = r_fifo_idx[r_rp];
                    end else if (if_req) begin
                        tbl_en   = 1'b1;
                        tbl_addr = if_idx;
                    end
                end
                UPD: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = r_upd_idx;
                    tbl_wdata = w_next_ctr;
                end
                default: ;
            endcase
        end
    end

    assign if_gnt     = !rst && w_gnt;
    assign pred_valid = !rst && r_pred_valid;
    assign pred_taken = pred_valid && tbl_rdata[1];
    assign init_done  = !rst && r_init_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= INIT;
            r_sweep      <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_upd_idx    <= '0;
            r_upd_tkn    <= 1'b0;
            r_init_done  <= 1'b0;
            r_pred_valid <= 1'b0;
        end else begin
            r_pred_valid <= w_gnt;
            case (r_state)
                INIT: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == '1) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (w_pop) begin
                        r_upd_idx <= r_fifo_idx[r_rp];
                        r_upd_tkn <= r_fifo_tkn[r_rp];
                        r_state   <= UPD;
                    end
                end
                UPD:     r_state <= IDLE;
                default: r_state <= INIT;
            endcase

            if (w_push) begin
                r_fifo_idx[r_wp] <= ex_idx;
                r_fifo_tkn[r_wp] <= ex_taken;
                r_wp             <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

`ifdef PRED_SCHED_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_deny_cnt;
    logic        w_drop;
    logic        w_deny;

    assign w_drop = ex_valid && w_full && !w_pop;
    assign w_deny = if_req && !w_gnt && r_init_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_deny_cnt <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_deny && (r_deny_cnt != '1)) r_deny_cnt <= r_deny_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign deny_cnt = r_deny_cnt;
`endif
endmodule

// File: tb/tb_pred_sched.sv
// Scoreboard bench for pred_sched: queue-level reference model of the PHT, update FIFO and port arbitration.
module tb_pred_sched;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned QDEPTH = 4;
    localparam int unsigned NENT   = 1 << IDX_W;
    localparam int unsigned PER    = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             if_req = 1'b0;
    logic [IDX_W-1:0] if_idx = '0;
    logic             ex_valid = 1'b0;
    logic [IDX_W-1:0] ex_idx = '0;
    logic             ex_taken = 1'b0;
    logic             if_gnt, pred_valid, pred_taken, init_done, tbl_en, tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata = 2'b00;
`ifdef PRED_SCHED_STATS_EN
    logic [15:0]      drop_cnt, deny_cnt;
`endif

    pred_sched #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_idx(if_idx), .if_gnt(if_gnt),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_taken(ex_taken),
        .init_done(init_done),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
`ifdef PRED_SCHED_STATS_EN
        , .drop_cnt(drop_cnt), .deny_cnt(deny_cnt)
`endif
    );

    always #(PER/2) clk = ~clk;

    // Single-port table RAM, 1-cycle read latency; non-read cycles return noise
    logic [1:0] mem [NENT];
    always @(posedge clk) begin
        if (tbl_en && tbl_we) mem[tbl_addr] <= tbl_wdata;
        if (tbl_en && !tbl_we) tbl_rdata <= mem[tbl_addr];
        else tbl_rdata <= 2'($urandom);
    end

    typedef struct { logic [IDX_W-1:0] idx; logic t; } upd_t;
    typedef struct { logic v; time t; } pred_t;

    int checks = 0;
    int failures = 0;
    upd_t  pend[$];
    pred_t pred_q[$];
    logic [1:0] model [NENT];
    int   cyc = 0;
    logic prev_pop = 1'b0;
    upd_t cur;
    int   drops = 0;
    int   denies = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        int v;
        v = int'(c);
        v = t ? v + 1 : v - 1;
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    // Port / FIFO / table-content monitor
    always @(negedge clk) begin : mon_port
        upd_t u;
        logic exp_pop, exp_gnt;
        logic [1:0] nv;
        pred_t p;
        if (rst) begin
            chk("rst_outputs", {if_gnt, pred_valid, pred_taken, init_done, tbl_en, tbl_we, tbl_addr, tbl_wdata}, '0);
            pend.delete();
            prev_pop = 1'b0;
            cyc = 0;
            drops = 0;
            denies = 0;
        end else begin
            chk("init_done", init_done, (cyc >= NENT));
            u.idx = ex_idx;
            u.t   = ex_taken;
            if (cyc < NENT) begin
                chk("init_write", {if_gnt, tbl_en, tbl_we, tbl_addr, tbl_wdata},
                    {1'b0, 1'b1, 1'b1, IDX_W'(cyc), 2'b00});
                model[cyc] = 2'b00;
                if (ex_valid) begin
                    if (pend.size() < QDEPTH) pend.push_back(u);
                    else drops++;
                end
                prev_pop = 1'b0;
            end else begin
                exp_pop = !prev_pop && (pend.size() > 0) && ((pend.size() == QDEPTH) || !if_req);
                exp_gnt = !prev_pop && if_req && !exp_pop;
                chk("if_gnt", if_gnt, exp_gnt);
                if (prev_pop) begin
                    nv = sat(model[cur.idx], cur.t);
                    chk("upd_write", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {2'b11, cur.idx, nv});
                    model[cur.idx] = nv;
                end else if (exp_pop) begin
                    chk("upd_read", {tbl_en, tbl_we, tbl_addr}, {2'b10, pend[0].idx});
                end else if (exp_gnt) begin
                    chk("lookup_read", {tbl_en, tbl_we, tbl_addr}, {2'b10, if_idx});
                end else begin
                    chk("port_idle", tbl_en, 1'b0);
                end
                if (exp_gnt) begin
                    p.v = model[if_idx][1];
                    p.t = $time;
                    pred_q.push_back(p);
                end
                if (if_req && !exp_gnt) denies++;
                if (exp_pop) cur = pend.pop_front();
                if (ex_valid) begin
                    if (pend.size() < QDEPTH) pend.push_back(u);
                    else drops++;
                end
                prev_pop = exp_pop;
            end
            cyc++;
        end
    end

    // Prediction monitor: each grant must yield exactly one result one cycle later
    always @(negedge clk) begin : mon_pred
        logic exp_pv;
        pred_t e;
        if (rst) begin
            pred_q.delete();
        end else begin
            exp_pv = (pred_q.size() > 0) && (pred_q[0].t + PER == $time);
            chk("pred_valid", pred_valid, exp_pv);
            if (exp_pv) begin
                e = pred_q.pop_front();
                if (pred_valid) chk("pred_taken", pred_taken, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int limit);
        int k;
        k = 0;
        if_req = 1'b0;
        ex_valid = 1'b0;
        while (!((cyc > NENT) && (pend.size() == 0) && !prev_pop) && (k < limit)) begin
            tick();
            k++;
        end
        chk("drain_timeout", (k < limit), 1'b1);
        repeat (2) tick();
    endtask

    task automatic lookup(input logic [IDX_W-1:0] idx);
        if_req = 1'b1;
        if_idx = idx;
        tick();
        if_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic update(input logic [IDX_W-1:0] idx, input logic t);
        ex_valid = 1'b1;
        ex_idx   = idx;
        ex_taken = t;
        tick();
        ex_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #(PER * 100000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Six back-to-back updates during the sweep: four kept, two dropped
        for (int i = 0; i < 6; i++) begin
            ex_valid = 1'b1;
            ex_idx   = IDX_W'(i * 7 + 3);
            ex_taken = i[0];
            tick();
        end
        ex_valid = 1'b0;
        chk("drops_during_init", drops, 2);
        wait_drained(NENT + 100);

        lookup(8'h05);
        for (int i = 0; i < 4; i++) update(8'h05, 1'b1);
        lookup(8'h05);
        for (int i = 0; i < 2; i++) update(8'h05, 1'b0);
        lookup(8'h05);
        wait_drained(50);

        // Saturated lookup stream against a burst of four updates
        if_req = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if_idx   = IDX_W'($urandom_range(0, 7));
            ex_valid = (i < 4);
            ex_idx   = IDX_W'($urandom_range(0, 7));
            ex_taken = 1'($urandom);
            tick();
        end
        wait_drained(50);

        for (int i = 0; i < 1500; i++) begin
            if_req   = ($urandom_range(0, 99) < 60);
            if_idx   = IDX_W'($urandom_range(0, 7));
            ex_valid = ($urandom_range(0, 99) < 45);
            ex_idx   = IDX_W'($urandom_range(0, 7));
            ex_taken = 1'($urandom);
            tick();
        end
        wait_drained(100);

        // Reset landing in an update write cycle with entries still queued
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1;
            ex_idx   = IDX_W'(8'h20 + i);
            ex_taken = 1'b1;
            tick();
        end
        ex_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (prev_pop) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("upd_reached", found, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_drained(NENT + 100);

        for (int i = 0; i < 200; i++) begin
            if_req   = ($urandom_range(0, 99) < 50);
            if_idx   = IDX_W'($urandom_range(0, 15));
            ex_valid = ($urandom_range(0, 99) < 30);
            ex_idx   = IDX_W'($urandom_range(0, 15));
            ex_taken = 1'($urandom);
            tick();
        end
        wait_drained(100);

        chk("pred_q_empty", pred_q.size(), 0);
`ifdef PRED_SCHED_STATS_EN
        chk("drop_cnt", drop_cnt, (drops > 65535) ? 65535 : drops);
        chk("deny_cnt", deny_cnt, (denies > 65535) ? 65535 : denies);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pred_sched.md
# pred_sched

Scheduler that owns the single-port 256×2-bit branch pattern-history table (PHT) in the fetch path. It clears the table after reset, shares the one table port between IF-stage prediction lookups and EX-stage resolution updates, and turns each update into a read-modify-write of a 2-bit saturating counter. Updates are buffered in a small FIFO so EX never stalls.

## Interface
- IDX_W, 8: PHT index width; the table holds 2^IDX_W entries.
- QDEPTH, 4: depth of the update FIFO (power of two, at least 2).

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  IF requests a prediction
- if_idx  in  IDX_W  lookup index
- if_gnt  out  1  lookup issued to table this cycle
- pred_valid  out  1  pred_taken valid (cycle after if_gnt)
- pred_taken  out  1  predicted direction
- ex_valid  in  1  EX branch resolved
- ex_idx  in  IDX_W  index of resolved branch
- ex_taken  in  1  actual direction
- init_done  out  1  table clear sweep finished
- tbl_en  out  1  table port enable
- tbl_we  out  1  write enable
- tbl_addr  out  IDX_W  table address
- tbl_wdata  out  2  write data
- tbl_rdata  in  2  read data, 1-cycle latency after a read

## Operation
- FSM states: INIT, IDLE, UPD.
- **INIT** (entered on rst):
  - Counter 0..2^IDX_W-1 writes 2'b00 to each index, one write per cycle.
  - Leaves for IDLE after the last index; init_done rises then and stays 1 until the next rst.
  - if_gnt=0 throughout; ex updates are still enqueued.
- **IDLE**, priority in this order:
  - FIFO full and non-empty: pop the head and issue a read of the head index → UPD. if_gnt=0.
  - Else if_req: issue a read of if_idx, if_gnt=1, stay IDLE.
  - Else FIFO non-empty: pop and read the head → UPD.
- **UPD**, one cycle:
  - Write the next-state counter to the captured index, tbl_we=1 → IDLE. if_gnt=0.
  - Next-state counter from tbl_rdata: 11 →(T)11 / (N)10; 10 → 11 / 01; 01 → 10 / 00; 00 → 01 / 00.
  - Saturates; never wraps.
- **Lookup result:** pred_valid=1 the cycle after if_gnt, with pred_taken = tbl_rdata[1].
- **FIFO:**
  - ex_valid pushes {ex_idx, ex_taken}.
  - Push while full with no pop in the same cycle: the entry is dropped (EX is not back-pressured).
  - Push and pop in the same cycle while full: the push is accepted.
- **Hazard:** a lookup reading an index with a queued update gets the stale counter. This is accepted; there is no forwarding.
- **Ordering:** updates to the same index are applied in FIFO order.

## Timing
- rst held: state=INIT, counter=0, FIFO empty, all outputs 0.
- First clear write occurs in the first cycle after rst deasserts.
- init_done=1 exactly 2^IDX_W cycles after rst deasserts.
- Lookup latency: if_req in cycle N (granted) → pred_valid in N+1.
- Update occupancy: 2 port cycles (read, then write). Back-to-back updates give one lookup slot between them unless the FIFO is full.
- Reset mid-UPD: the write is abandoned, the FIFO is cleared, and the sweep restarts.
- rst in the cycle after if_gnt: pred_valid=0.

## Configuration
- PRED_SCHED_STATS_EN defined: adds two outputs, each 16-bit, saturating, cleared by rst.
  - drop_cnt counts FIFO-overflow drops.
  - deny_cnt counts cycles with if_req=1 and if_gnt=0 after init_done.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then idle 256 cycles → 256 writes of 2'b00 to addresses 0..255 in order; init_done=1 at cycle 256.
- After init, if_req idx=0x05 → if_gnt=1, next cycle pred_valid=1, pred_taken=0.
- Four ex_valid taken updates to idx 0x05 → writes 01, 10, 11, 11; a following lookup returns pred_taken=1. Two not-taken updates → 10, 01, then pred_taken=0.
- Hold if_req=1 and push 4 updates → every lookup is granted until the FIFO is full; then the update wins (if_gnt=0 for 2 cycles) and the FIFO drains one entry per full event.
- Push 6 updates in consecutive cycles during INIT → the first 4 are kept and 2 are dropped (drop_cnt=2 with PRED_SCHED_STATS_EN); the kept updates apply in order after init_done.
- Assert rst during UPD → no write that cycle; the FIFO is empty; the sweep restarts at address 0.
